// File: rtl/push_fifo_pkg.sv
// push_fifo_pkg
// Shared types for the push-handshake word FIFO and the escape encoders.
//   WORDW       : width of one escaped memory word (16 bits)
//   in_state_t  : input-side handshake FSM states
//   out_state_t : output-side handshake FSM states
package push_fifo_pkg;

    localparam int WORDW = 16;

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_PEND = 2'd1,
        IN_DONE = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_t;

endpackage

// File: rtl/push_fifo_ram.sv
// push_fifo_ram
// DEPTH x WORDW storage for push_word_fifo. Synchronous write, asynchronous
// (combinational) read, no reset on the array contents.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write index
//   wdata in  write word
//   raddr in  read index
//   rdata out word at raddr (combinational)
module push_fifo_ram
    import push_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [WORDW-1:0] wdata,
    input  logic [ADDRW-1:0] raddr,
    output logic [WORDW-1:0] rdata
);

    logic [WORDW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/push_word_fifo.sv
// push_word_fifo
// Elastic buffer of escaped 16-bit memory words between the mil-to-memory
// escape encoder (push master) and the memory-to-mil decoder (push slave).
// Both sides use a request/done handshake; words are replayed in order and
// their contents are never interpreted.
//
// Optional build macro: PUSH_FIFO_FLUSH_EN adds a synchronous 'flush' input
// that empties the buffer and aborts any in-flight handshake.
//
// Ports:
//   clk         in  clock
//   nRst        in  synchronous active-low reset
//   flush       in  (PUSH_FIFO_FLUSH_EN only) clear buffer
//   in_request  in  upstream word available, sampled only in IN_IDLE
//   in_data     in  upstream word, captured with in_request
//   in_done     out one-cycle pulse: word accepted (or dropped by flush)
//   out_request out one-cycle pulse: out_data valid
//   out_data    out head word, stable from out_request until out_done
//   out_done    in  downstream consumed the word, honoured only in OUT_WAIT
//   count       out words stored
//   full        out count == DEPTH
//   empty       out count == 0
//
// Handshake: each side moves exactly one word per request/done pair. The
// master holds its word in hold_reg until space exists; the slave sees a
// registered copy of the head word that cannot change until it answers.
module push_word_fifo
    import push_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nRst,
`ifdef PUSH_FIFO_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_request,
    input  logic [WORDW-1:0] in_data,
    output logic             in_done,
    output logic             out_request,
    output logic [WORDW-1:0] out_data,
    input  logic             out_done,
    output logic [ADDRW:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDRW:0] PTR_ONE  = (ADDRW+1)'(1);
    localparam logic [ADDRW:0] FULL_CNT = (ADDRW+1)'(DEPTH);

    in_state_t        in_state, in_state_n;
    out_state_t       out_state, out_state_n;
    logic [ADDRW:0]   wr_ptr, rd_ptr;
    logic [WORDW-1:0] hold_reg;
    logic [WORDW-1:0] ram_rdata;
    logic             wr_en;
    logic             rd_adv;
    logic             load_out;
    logic             flush_now;

`ifdef PUSH_FIFO_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Extra wrap bit makes the modular difference equal the fill level,
    // so full and empty are distinguishable without a separate counter.
    assign count       = wr_ptr - rd_ptr;
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign in_done     = (in_state == IN_DONE);
    assign out_request = (out_state == OUT_REQ);

    push_fifo_ram #(
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[ADDRW-1:0]),
        .wdata (hold_reg),
        .raddr (rd_ptr[ADDRW-1:0]),
        .rdata (ram_rdata)
    );

    // Input side: capture, wait for space, acknowledge.
    always_comb begin
        in_state_n = in_state;
        wr_en      = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (in_request && !flush_now) begin
                    in_state_n = IN_PEND;
                end
            end
            IN_PEND: begin
                // A flush drops the held word but still acknowledges it so
                // the master never waits forever.
                if (flush_now) begin
                    in_state_n = IN_DONE;
                end else if (!full) begin
                    wr_en      = 1'b1;
                    in_state_n = IN_DONE;
                end
            end
            IN_DONE: begin
                in_state_n = IN_IDLE;
            end
            default: begin
                in_state_n = IN_IDLE;
            end
        endcase
    end

    // Output side: present head word, pulse request, wait for consumer.
    always_comb begin
        out_state_n = out_state;
        rd_adv      = 1'b0;
        load_out    = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (!empty) begin
                    load_out    = 1'b1;
                    out_state_n = OUT_REQ;
                end
            end
            OUT_REQ: begin
                out_state_n = OUT_WAIT;
            end
            OUT_WAIT: begin
                if (out_done) begin
                    rd_adv      = 1'b1;
                    out_state_n = OUT_IDLE;
                end
            end
            default: begin
                out_state_n = OUT_IDLE;
            end
        endcase
        if (flush_now) begin
            out_state_n = OUT_IDLE;
            rd_adv      = 1'b0;
            load_out    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            in_state  <= IN_IDLE;
            out_state <= OUT_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_reg  <= '0;
            out_data  <= '0;
        end else begin
            in_state  <= in_state_n;
            out_state <= out_state_n;
            if (in_state == IN_IDLE && in_request && !flush_now) begin
                hold_reg <= in_data;
            end
            if (flush_now) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            if (load_out) begin
                out_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_push_word_fifo.sv
// tb_push_word_fifo
// Self-checking bench for push_word_fifo (DEPTH=16). Build with
// +define+PUSH_FIFO_FLUSH_EN to include the flush sequence.
module tb_push_word_fifo;
    import push_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int ADDRW = 4;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic             in_request = 1'b0;
    logic [WORDW-1:0] in_data = '0;
    logic             out_done = 1'b0;
`ifdef PUSH_FIFO_FLUSH_EN
    logic             flush = 1'b0;
`endif
    logic             in_done;
    logic             out_request;
    logic [WORDW-1:0] out_data;
    logic [ADDRW:0]   count;
    logic             full;
    logic             empty;

    always #5 clk = ~clk;

    push_word_fifo #(
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
`ifdef PUSH_FIFO_FLUSH_EN
        .flush       (flush),
`endif
        .in_request  (in_request),
        .in_data     (in_data),
        .in_done     (in_done),
        .out_request (out_request),
        .out_data    (out_data),
        .out_done    (out_done),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // ---------------- scoreboard state ----------------
    int               n_cmp = 0;
    int               n_fail = 0;
    logic [WORDW-1:0] exp_q[$];
    logic [WORDW-1:0] cur_exp = '0;
    bit               holding = 1'b0;
    bit               resp_en = 1'b0;
    int               resp_fixed = 0;
    int               max_cnt = 0;

    typedef struct {
        logic [WORDW-1:0] data;
        logic [ADDRW:0]   exp_count;
        logic             exp_full;
        logic             exp_empty;
    } fill_vec_t;

    fill_vec_t vecs[DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one word and wait (bounded) for in_done; returns on the negedge
    // where in_done is high.
    task automatic push_word(input logic [WORDW-1:0] d);
        int k;
        exp_q.push_back(d);
        in_request = 1'b1;
        in_data    = d;
        tick();
        in_request = 1'b0;
        k = 0;
        while (!in_done && k < 200) begin
            tick();
            k++;
        end
        check("in_done_wait", 32'(k < 200), 32'd1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !empty || holding) && k < 3000) begin
            tick();
            k++;
        end
        check("drain_done", 32'(k < 3000), 32'd1);
        check("count_after_drain", 32'(count), 32'd0);
    endtask

    // ---------------- output monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!nRst) begin
                holding = 1'b0;
            end else begin
                if (int'(count) > max_cnt) max_cnt = int'(count);
                if (holding) begin
                    check("out_data_stable", 32'(out_data), 32'(cur_exp));
                    if (out_done) holding = 1'b0;
                end
                if (out_request) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(cur_exp));
                        holding = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- downstream responder ----------------
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (resp_en && out_request) begin
                d = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(1, 6));
                repeat (d) @(negedge clk);
                out_done = 1'b1;
                @(negedge clk);
                out_done = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit done_seen;

        for (int i = 0; i < DEPTH; i++) begin
            vecs[i] = '{data: WORDW'(i), exp_count: (ADDRW+1)'(i + 1),
                        exp_full: (i == DEPTH - 1), exp_empty: 1'b0};
        end

        // Reset state
        nRst = 1'b0;
        repeat (2) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_done", 32'(in_done), 32'd0);
        check("rst_out_request", 32'(out_request), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        nRst = 1'b1;
        tick();

        // Pass-through timing on an empty FIFO
        resp_en    = 1'b1;
        resp_fixed = 2;
        exp_q.push_back(16'h1234);
        in_request = 1'b1;
        in_data    = 16'h1234;
        tick();
        in_request = 1'b0;
        check("pt_in_done_t1", 32'(in_done), 32'd0);
        tick();
        check("pt_in_done_t2", 32'(in_done), 32'd1);
        check("pt_out_req_t2", 32'(out_request), 32'd0);
        tick();
        check("pt_out_req_t3", 32'(out_request), 32'd1);
        tick();
        tick();
        check("pt_count_t5", 32'(count), 32'd1);
        tick();
        check("pt_count_t6", 32'(count), 32'd0);
        check("pt_empty_t6", 32'(empty), 32'd1);
        repeat (2) tick();

        // Fill to full with no consumer (table-driven)
        resp_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_word(vecs[i].data);
            check("fill_count", 32'(count), 32'(vecs[i].exp_count));
            check("fill_full", 32'(full), 32'(vecs[i].exp_full));
            check("fill_empty", 32'(empty), 32'(vecs[i].exp_empty));
            tick();
        end

        // 17th word blocks while full
        exp_q.push_back(16'hBEEF);
        in_request = 1'b1;
        in_data    = 16'hBEEF;
        tick();
        in_request = 1'b0;
        done_seen  = 1'b0;
        repeat (6) begin
            tick();
            if (in_done) done_seen = 1'b1;
        end
        check("full_no_in_done", 32'(done_seen), 32'd0);
        check("full_count", 32'(count), 32'd16);

        // One consume frees space; the held word lands one cycle later
        out_done = 1'b1;
        tick();
        out_done   = 1'b0;
        resp_fixed = 0;
        resp_en    = 1'b1;
        check("free_count", 32'(count), 32'd15);
        check("free_in_done_early", 32'(in_done), 32'd0);
        tick();
        check("free_in_done", 32'(in_done), 32'd1);
        check("free_count_refill", 32'(count), 32'd16);
        wait_drain();

        // Wrap-around stream with random consumer delay
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            push_word(WORDW'($urandom_range(0, 65535)));
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain();
        check("max_count_le_depth", 32'(max_cnt <= DEPTH), 32'd1);

        // Escape pair replayed unchanged, data held until out_done
        resp_fixed = 3;
        push_word(16'hFFA1);
        tick();
        push_word(16'h4321);
        tick();
        wait_drain();

        // Reset in mid-operation
        resp_en    = 1'b0;
        resp_fixed = 0;
        for (int i = 0; i < 5; i++) begin
            push_word(16'h0A00 + WORDW'(i));
            tick();
        end
        in_request = 1'b1;
        in_data    = 16'hDEAD;
        tick();
        in_request = 1'b0;
        nRst       = 1'b0;
        tick();
        nRst = 1'b1;
        exp_q.delete();
        holding = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_in_done", 32'(in_done), 32'd0);
        check("mid_rst_out_request", 32'(out_request), 32'd0);
        tick();
        check("mid_rst_in_done_late", 32'(in_done), 32'd0);
        out_done = 1'b1;
        tick();
        out_done = 1'b0;
        tick();
        check("mid_rst_late_done_count", 32'(count), 32'd0);
        check("mid_rst_late_done_empty", 32'(empty), 32'd1);
        repeat (4) tick();

`ifdef PUSH_FIFO_FLUSH_EN
        // Flush with three stored words and one pending
        for (int i = 0; i < 3; i++) begin
            push_word(16'h0B00 + WORDW'(i));
            tick();
        end
        in_request = 1'b1;
        in_data    = 16'hCAFE;
        tick();
        in_request = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        holding = 1'b0;
        check("flush_in_done", 32'(in_done), 32'd1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_request", 32'(out_request), 32'd0);
        out_done = 1'b1;
        tick();
        out_done = 1'b0;
        repeat (5) tick();
        check("flush_late_done_count", 32'(count), 32'd0);
        resp_en = 1'b1;
        push_word(16'h7777);
        tick();
        wait_drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/push_word_fifo.md
Name: push_word_fifo

Overview:
- Elastic word buffer between the mil-to-memory escape encoder (upstream, push master) and the memory-to-mil decoder (downstream, push slave).
- Stores escaped 16-bit memory words in a circular buffer.
- Accepts words with a request/done handshake on the input side and replays them in order with the same handshake on the output side.
- Decouples line-side and SPI-side timing and gives backpressure when full.

Parameters:
- DEPTH, 16, number of 16-bit words stored; must be a power of two, at least 2.
- ADDRW, $clog2(DEPTH), pointer index width; pointers carry one extra wrap bit.

Ports:
- clk  in  1  clock
- nRst  in  1  reset, synchronous, active-low
- in_request  in  1  upstream word available; pulse or level, sampled only in IN_IDLE
- in_data  in  16  upstream word; captured on the cycle in_request is sampled
- in_done  out  1  one-cycle pulse: word accepted (or dropped by flush)
- out_request  out  1  one-cycle pulse: out_data valid
- out_data  out  16  head word; stable from out_request until out_done
- out_done  in  1  downstream consumed word; honoured only in OUT_WAIT
- count  out  ADDRW+1  words stored, registered
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (nRst=0 at posedge): wr_ptr, rd_ptr and count are 0; both FSMs go to IDLE; in_done=0, out_request=0, out_data=0, empty=1, full=0.
- Reset mid-operation discards stored words and any in-flight handshake. No in_done is issued for a word captured before the reset.
- Pointers are ADDRW+1 bits. Index is ptr[ADDRW-1:0] and wraps naturally.
- count = wr_ptr - rd_ptr, modulo 2^(ADDRW+1).
- Input FSM IN_IDLE -> IN_PEND -> IN_DONE -> IN_IDLE:
  - IN_IDLE: if in_request, latch in_data into hold_reg, go to IN_PEND.
  - IN_PEND: if !full, write hold_reg at wr_ptr, increment wr_ptr, go to IN_DONE. If full, stay (backpressure, no timeout).
  - IN_DONE: in_done=1 for one cycle, go to IN_IDLE.
  - in_request while not in IN_IDLE is ignored.
  - Latency from in_request to in_done is 2 cycles when not full.
- Output FSM OUT_IDLE -> OUT_REQ -> OUT_WAIT -> OUT_IDLE:
  - OUT_IDLE: if !empty, register out_data <= mem[rd_ptr], go to OUT_REQ.
  - OUT_REQ: out_request=1 for one cycle, go to OUT_WAIT.
  - OUT_WAIT: on out_done, increment rd_ptr, go to OUT_IDLE.
  - out_done in OUT_IDLE or OUT_REQ is ignored.
  - The rd_ptr increment takes effect one cycle after out_done. The next word's out_request follows 2 cycles after that.
- Empty-FIFO pass-through: in_request at cycle t gives a write at the end of t+1, in_done at t+2 and out_request at t+3.
- A simultaneous write (IN_PEND) and read (OUT_WAIT + out_done) updates both pointers in the same cycle; count is unchanged.
- Full with a read in the same cycle: the IN_PEND write waits one cycle because the full check uses registered count. The word is written the cycle after the read frees space.
- A word written in cycle t is visible to OUT_IDLE in cycle t+1. There is no bypass path.
- Word content is opaque: escape words (0xFFA0..0xFFA3) are stored and replayed unchanged, preserving pairs.
- Memory: synchronous write, combinational read.

Optional Feature:
- Macro: PUSH_FIFO_FLUSH_EN.
- With it: an extra input port flush (1 bit) is added. While flush=1 at posedge:
  - wr_ptr=rd_ptr=0.
  - Output FSM goes to OUT_IDLE, and out_request drops.
  - Input FSM in IN_PEND goes to IN_DONE without writing, so the master still gets in_done and does not hang.
  - Input FSM in IN_IDLE ignores in_request.
  - A late out_done after flush is ignored.
- Without it: no flush port; only nRst clears the buffer.

Decomposition:
- Shared package push_fifo_pkg: in_state_t and out_state_t enums, and localparam WORDW=16 (reused by the escape encoders).
- Escape constants stay in their existing shared header; the FIFO does not reference them.
- One sub-module: push_fifo_ram (DEPTH x 16, write port we/waddr/wdata, asynchronous read port raddr/rdata).
- FSMs and pointers stay in push_word_fifo.

Test Plan:
- Pass-through: empty FIFO, in_request with 0x1234 at t0 -> in_done at t2, out_request at t3 with out_data=0x1234. out_done at t5 -> count returns to 0 at t6.
- Fill: push 16 words 0x0000..0x000F with no out_done -> full=1, count=16. A 17th in_request (0xBEEF) gets no in_done. One out_done -> 0x0000 consumed, then 0xBEEF written and in_done fires. Draining yields 0x0001..0x000F, 0xBEEF in order.
- Wrap: 40 words streamed with random out_done delay (0-5 cycles) -> output order equals input order, count never exceeds 16.
- Escape pair: push 0xFFA1 then 0x4321 -> replayed as 0xFFA1, 0x4321. out_data stays stable from out_request through out_done.
- Reset mid-op: 5 words stored, output in OUT_WAIT, in FSM in IN_PEND; nRst=0 for one cycle -> count=0, empty=1, no in_done, out_request=0. A later out_done is ignored.
- Flush (PUSH_FIFO_FLUSH_EN): 3 stored plus one in IN_PEND, flush pulse -> in_done next cycle, count=0, the pending word is never output.
